// File: rtl/si_ifu_pkg.sv
// si_ifu_pkg: shared definitions for the instruction fetch unit.
//   PC_START_DEFAULT : reset PC used when the top is not overridden.
//   FIFO_DEPTH       : instruction queue depth (fixed at 2).
//   state_t          : fetch FSM encoding (IDLE / WAIT / WAIT_KILL).
package si_ifu_pkg;

   localparam logic [31:0] PC_START_DEFAULT = 32'h8000_0000;
   localparam int unsigned FIFO_DEPTH       = 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,  // no outstanding request
      ST_WAIT      = 2'd1,  // outstanding request, response will be kept
      ST_WAIT_KILL = 2'd2   // outstanding request, response will be dropped
   } state_t;

endpackage

// File: rtl/si_ifu_fifo.sv
// si_ifu_fifo: 2-entry synchronous FIFO holding {pc, inst} records.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din at the tail
//   pop      : drop the head entry
//   flush    : empty the queue (overrides push/pop)
//   din      : entry to write
//   count    : number of valid entries (0..2)
//   head     : current head entry (meaningless when count == 0)
module si_ifu_fifo
   import si_ifu_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign count = cnt;
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/si_ifu.sv
// si_ifu: single-issue instruction fetch unit.
// Owns the PC, issues word fetches (at most one outstanding) and buffers
// returned instructions in a 2-entry queue toward decode. A redirect from
// the ALU flushes the queue, reloads the PC and kills any in-flight fetch.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   redirect_en_i   : redirect request (taken branch / jump)
//   redirect_pc_i   : redirect target (low 2 bits ignored)
//   imem_req_o      : fetch request valid
//   imem_addr_o     : fetch address (current PC)
//   imem_gnt_i      : memory accepts the request this cycle
//   imem_rvalid_i   : read data valid
//   imem_rdata_i    : returned instruction
//   inst_valid_o    : queue head valid toward decode
//   inst_ready_i    : decode accepts the head
//   inst_o          : head instruction
//   inst_pc_o       : PC of the head instruction
module si_ifu
   import si_ifu_pkg::*;
#(
   parameter int unsigned         INST_DW  = 32,
   parameter int unsigned         INST_AW  = 32,
   parameter logic [INST_AW-1:0]  PC_START = PC_START_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_en_i,
   input  logic [INST_AW-1:0] redirect_pc_i,
   output logic               imem_req_o,
   output logic [INST_AW-1:0] imem_addr_o,
   input  logic               imem_gnt_i,
   input  logic               imem_rvalid_i,
   input  logic [INST_DW-1:0] imem_rdata_i,
   output logic               inst_valid_o,
   input  logic               inst_ready_i,
   output logic [INST_DW-1:0] inst_o,
   output logic [INST_AW-1:0] inst_pc_o
);

   localparam logic [INST_AW-1:0] WORD_MASK = {{(INST_AW-2){1'b1}}, 2'b00};
   localparam logic [INST_AW-1:0] PC_STEP   = {{(INST_AW-3){1'b0}}, 3'b100};

   state_t                      state_q;
   logic [INST_AW-1:0]          pc_q;
   logic [INST_AW-1:0]          req_pc_q;
   logic [1:0]                  count;
   logic [INST_AW+INST_DW-1:0]  head;
   logic                        issue;
   logic                        push;
   logic                        pop;
   logic [INST_AW-1:0]          redirect_target;

   assign redirect_target = redirect_pc_i & WORD_MASK;

   assign imem_req_o   = !rst && !redirect_en_i && (state_q == ST_IDLE) &&
                         (count < 2'(FIFO_DEPTH));
   assign imem_addr_o  = pc_q;
   assign issue        = imem_req_o && imem_gnt_i;

   assign inst_valid_o = (count != 2'd0) && !redirect_en_i;
   assign pop          = inst_valid_o && inst_ready_i;
   // Only a kept response is queued; redirect drops a same-cycle response.
   assign push         = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_en_i;

   assign inst_pc_o    = head[INST_AW+INST_DW-1:INST_DW];
   assign inst_o       = head[INST_DW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= PC_START;
         req_pc_q <= '0;
      end else if (redirect_en_i) begin
         pc_q <= redirect_target;
         // A fetch still in flight must be swallowed when it returns;
         // one returning right now is simply discarded.
         if ((state_q != ST_IDLE) && !imem_rvalid_i) begin
            state_q <= ST_WAIT_KILL;
         end else begin
            state_q <= ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  req_pc_q <= pc_q;
                  pc_q     <= pc_q + PC_STEP;
                  state_q  <= ST_WAIT;
               end
            end
            ST_WAIT, ST_WAIT_KILL: begin
               if (imem_rvalid_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   si_ifu_fifo #(
      .WIDTH(INST_AW + INST_DW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_en_i),
      .din   ({req_pc_q, imem_rdata_i}),
      .count (count),
      .head  (head)
   );

endmodule

// File: doc/si_ifu.md
Name: si_ifu

Overview:
- Single-issue instruction fetch unit: owns the PC, issues word fetches to instruction memory and buffers returned instructions for decode.
- Sits directly upstream of decode/ALU and consumes the ALU's control_en_o/control_pc_o as a redirect (taken branch or jump).
- Holds a 2-entry instruction queue and allows at most one outstanding memory request.

Parameters:
- PC_START, 32'h8000_0000, PC value loaded on reset.
- INST_DW, 32, instruction width.
- INST_AW, 32, address/PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect_en_i  in  1  redirect request; driven by ALU control_en_o.
- redirect_pc_i  in  INST_AW  redirect target; driven by ALU control_pc_o.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  INST_AW  fetch address (word aligned).
- imem_gnt_i  in  1  memory accepts request this cycle (req & gnt = issue).
- imem_rvalid_i  in  1  read data valid; arrives at least 1 cycle after the grant.
- imem_rdata_i  in  INST_DW  returned instruction.
- inst_valid_o  out  1  queue head valid toward decode.
- inst_ready_i  in  1  decode accepts head (valid & ready = pop).
- inst_o  out  INST_DW  head instruction.
- inst_pc_o  out  INST_AW  PC of head instruction.

Behaviour:
- Reset (async, any time): pc_q = PC_START, queue count = 0, outstanding = 0, kill = 0.
  - All outputs reset to 0, except imem_addr_o = PC_START.
  - A memory response in flight at reset is dropped, because outstanding = 0.
- State: pc_q, req_pc_q (PC of the outstanding request), outstanding flag, kill flag, 2-entry FIFO of {pc, inst}.
- FSM:
  - IDLE: no outstanding request.
  - WAIT: outstanding request, response will be kept.
  - WAIT_KILL: outstanding request, response will be discarded.
- Request rule:
  - imem_req_o = !rst & !redirect_en_i & state==IDLE & (count < 2).
  - imem_addr_o = pc_q.
  - On req & gnt: req_pc_q = pc_q, pc_q += 4 (wraps mod 2^INST_AW), state -> WAIT.
- Response rule:
  - In WAIT with imem_rvalid_i: push {req_pc_q, imem_rdata_i} into the FIFO, state -> IDLE.
  - In WAIT_KILL with imem_rvalid_i: discard the data, state -> IDLE.
  - In IDLE, imem_rvalid_i is ignored.
  - The next request may issue in the cycle after the response (one outstanding only, so at most one fetch per 2 cycles).
- Queue output:
  - inst_valid_o = (count != 0) & !redirect_en_i.
  - inst_o and inst_pc_o always reflect the head entry.
  - Push and pop in the same cycle leave count unchanged.
  - Push when count == 2 cannot occur: the request rule guarantees a free slot.
- Redirect (redirect_en_i = 1), takes priority over everything else:
  - Next cycle: FIFO flushed (count = 0), pc_q = {redirect_pc_i[INST_AW-1:2], 2'b00}.
  - If state is WAIT and imem_rvalid_i is low this cycle: state -> WAIT_KILL. Otherwise state -> IDLE and any same-cycle response is discarded.
  - No request and no pop occur in the redirect cycle.
  - A second redirect while in WAIT_KILL stays in WAIT_KILL and takes the new PC.
- Latency: reset release -> first imem_req_o in the same cycle rst is low. Grant -> earliest inst_valid_o is rvalid cycle + 1.

Decomposition:
- Shared defines header: PC_START default and the IDLE/WAIT/WAIT_KILL encodings (2-bit).
- One sub-module, si_ifu_fifo: 2-entry synchronous FIFO of width INST_AW+INST_DW, with push/pop/flush, count, head outputs and async reset.

Test Plan:
- Reset, gnt always 1, rvalid 1 cycle after gnt with rdata = 0x00000013, ready = 1 -> addresses 0x80000000, 0x80000004, 0x80000008; inst_pc_o follows the same sequence, one instruction every 2 cycles.
- Backpressure: ready = 0 -> exactly 2 fetches complete, count = 2, imem_req_o stays 0. Raise ready -> entries pop in order and fetching resumes at 0x80000008.
- Redirect while in WAIT (target 0x80000100, rvalid arrives 2 cycles later with 0xDEADBEEF) -> 0xDEADBEEF never appears on inst_o; the next request address is 0x80000100 after the killed response returns.
- Redirect in the same cycle as rvalid, target 0x80000203 -> response dropped, FIFO flushed, next imem_addr_o = 0x80000200, inst_valid_o low in the redirect cycle.
- Async rst asserted mid-WAIT, then rvalid arrives -> response ignored, count = 0, imem_addr_o = 0x80000000 immediately after reset.
- PC wrap: redirect to 0xFFFFFFFC, grant issued -> next imem_addr_o = 0x00000000.
